// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage memory access controller.
`timescale 1ns/1ps
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 8;

  // Load result reported when an access is abandoned by the timeout.
  localparam logic [7:0] TIMEOUT_DATA = 8'hFF;

endpackage

// File: rtl/sync_2ff.sv
// Parameterised-width two-flop synchroniser for asynchronous inputs.
`timescale 1ns/1ps
module sync_2ff #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage controller: req/ack data-memory access, pipeline stall, I/O ports.
// Optional access timeout is built when MEM_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W         = MEM_ADDR_W,
  parameter int DATA_W         = MEM_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              IO_Write,
  input  logic [ADDR_W-1:0] ALU_res,
  input  logic [DATA_W-1:0] Rd2,
  input  logic [DATA_W-1:0] IP,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] data_B,
  output logic [DATA_W-1:0] IP_sync,
  output logic [DATA_W-1:0] OUT_port,
  output logic              stall,
  output logic              mem_err
);

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t state;
  logic   access;

  // A simultaneous read and write request is treated as a write.
  assign access = valid & (MemRead | MemWrite);
  // Stall is forced low while reset is held so the pipeline is not frozen.
  assign stall  = rst & (((state == IDLE) & access) | (state == BUSY));

`ifdef MEM_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] busy_cnt;
  logic             timed_out;

  assign timed_out = (busy_cnt == CNT_LAST);
`else
  assign mem_err = 1'b0;
`endif

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // flop samples pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      data_B    <= '0;
      OUT_port  <= '0;
`ifdef MEM_TIMEOUT_EN
      busy_cnt  <= '0;
      mem_err   <= 1'b0;
`endif
    end else begin
`ifdef MEM_TIMEOUT_EN
      mem_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (access) begin
            mem_req   <= 1'b1;
            mem_we    <= MemWrite;
            mem_addr  <= ALU_res;
            mem_wdata <= Rd2;
            state     <= BUSY;
`ifdef MEM_TIMEOUT_EN
            busy_cnt  <= '0;
`endif
          end
        end
        BUSY: begin
          // An ack on the final timeout cycle still completes normally.
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) data_B <= mem_rdata;
            state   <= DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (timed_out) begin
            mem_req <= 1'b0;
            if (!mem_we) data_B <= DATA_W'(TIMEOUT_DATA);
            mem_err <= 1'b1;
            state   <= DONE;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // Gating on stall makes the port write happen once per instruction.
      if (valid & IO_Write & ~stall) OUT_port <= Rd2;
    end
  end

  sync_2ff #(.W(DATA_W)) u_ip_sync (
    .clk (clk),
    .rst (rst),
    .d   (IP),
    .q   (IP_sync)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomised self-checking bench for mem_access_stage with a transaction-level model.
`timescale 1ns/1ps
module tb_mem_access_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid, MemRead, MemWrite, IO_Write;
  logic [7:0] ALU_res, Rd2, IP;
  logic       mem_req, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic [7:0] data_B, IP_sync, OUT_port;
  logic       stall, mem_err;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk       (clk),
    .rst       (rst),
    .valid     (valid),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .IO_Write  (IO_Write),
    .ALU_res   (ALU_res),
    .Rd2       (Rd2),
    .IP        (IP),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .data_B    (data_B),
    .IP_sync   (IP_sync),
    .OUT_port  (OUT_port),
    .stall     (stall),
    .mem_err   (mem_err)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected per-cycle view derived from the instruction schedule.
  bit         exp_stall, exp_req, exp_we, exp_err;
  logic [7:0] exp_addr, exp_wdata, exp_data_b, exp_out;
  logic [7:0] ip_d1, ip_d2;
  bit         ip_hold;
  int         stall_run, last_stall_run, req_run, last_req_run, err_pulses;
  bit         seen_we;
  logic [7:0] seen_addr, seen_wdata;

  always @(negedge clk) begin
    if (!rst) begin
      ip_d1     = '0;
      ip_d2     = '0;
      stall_run = 0;
      req_run   = 0;
    end else begin
      check("stall", 32'(stall), 32'(exp_stall));
      check("mem_req", 32'(mem_req), 32'(exp_req));
      if (exp_req) begin
        check("mem_we", 32'(mem_we), 32'(exp_we));
        check("mem_addr", 32'(mem_addr), 32'(exp_addr));
        check("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
      end
      check("data_B", 32'(data_B), 32'(exp_data_b));
      check("OUT_port", 32'(OUT_port), 32'(exp_out));
      check("mem_err", 32'(mem_err), 32'(exp_err));
      check("IP_sync", 32'(IP_sync), 32'(ip_d2));
      ip_d2 = ip_d1;
      ip_d1 = IP;
      if (stall) stall_run++;
      else if (stall_run > 0) begin last_stall_run = stall_run; stall_run = 0; end
      if (mem_req) begin
        req_run++;
        seen_we    = mem_we;
        seen_addr  = mem_addr;
        seen_wdata = mem_wdata;
      end else if (req_run > 0) begin
        last_req_run = req_run;
        req_run      = 0;
      end
      if (mem_err) err_pulses++;
    end
  end

  // One pipeline cycle: set the expectations visible in it, then apply the edge.
  task automatic run_cycle(input bit s, input bit r, input bit ack, input logic [7:0] rd);
    exp_stall = s;
    exp_req   = r;
    mem_ack   = ack;
    mem_rdata = rd;
    if (!ip_hold) IP = 8'($urandom);
    @(posedge clk);
    #1;
    if (valid && IO_Write && !s) exp_out = Rd2;
    exp_err = 1'b0;
  endtask

  // Memory instruction: IDLE cycle, lat BUSY cycles (ack on the last if ack_ok), DONE.
  task automatic do_access(input bit rd, input bit wr, input bit io, input logic [7:0] addr,
                           input logic [7:0] wd, input int lat, input bit ack_ok,
                           input logic [7:0] rdata);
    valid     = 1'b1;
    MemRead   = rd;
    MemWrite  = wr;
    IO_Write  = io;
    ALU_res   = addr;
    Rd2       = wd;
    exp_we    = wr;
    exp_addr  = addr;
    exp_wdata = wd;
    run_cycle(1'b1, 1'b0, 1'b0, 8'h00);
    for (int k = 1; k <= lat; k++)
      run_cycle(1'b1, 1'b1, ack_ok && (k == lat), (k == lat) ? rdata : 8'($urandom));
    if (!wr) exp_data_b = ack_ok ? rdata : 8'hFF;
    exp_err = !ack_ok;
    run_cycle(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Non-memory cycle: bubbles carry random control bits; stray acks must be ignored.
  task automatic idle_cycle(input bit v, input bit io);
    valid = v;
    if (v) begin
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IO_Write = io;
    end else begin
      MemRead  = 1'($urandom);
      MemWrite = 1'($urandom);
      IO_Write = 1'($urandom);
    end
    Rd2     = 8'($urandom);
    ALU_res = 8'($urandom);
    run_cycle(1'b0, 1'b0, 1'($urandom), 8'($urandom));
  endtask

  initial begin
    rst = 1'b0;
    valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; IO_Write = 1'b0;
    ALU_res = 8'h00; Rd2 = 8'h00; IP = 8'hC3; mem_ack = 1'b0; mem_rdata = 8'h00;
    exp_stall = 0; exp_req = 0; exp_we = 0; exp_err = 0;
    exp_addr = 0; exp_wdata = 0; exp_data_b = 0; exp_out = 0;
    ip_hold = 0; last_stall_run = 0; last_req_run = 0; err_pulses = 0;
    seen_we = 0; seen_addr = 0; seen_wdata = 0;

    #12;
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    check("rst_data_B", 32'(data_B), 32'h0);
    check("rst_IP_sync", 32'(IP_sync), 32'h0);
    check("rst_OUT_port", 32'(OUT_port), 32'h0);
    check("rst_mem_err", 32'(mem_err), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);

    @(posedge clk); #1;
    rst = 1'b1;
    idle_cycle(1'b0, 1'b0);
    idle_cycle(1'b0, 1'b0);

    do_access(1'b1, 1'b0, 1'b0, 8'h3C, 8'h00, 3, 1'b1, 8'hA5);
    check("load_stall_cycles", 32'(last_stall_run), 32'd4);
    check("load_req_cycles", 32'(last_req_run), 32'd3);
    check("load_data", 32'(data_B), 32'hA5);

    do_access(1'b1, 1'b1, 1'b0, 8'h10, 8'h5A, 2, 1'b1, 8'h99);
    check("store_we", 32'(seen_we), 32'h1);
    check("store_addr", 32'(seen_addr), 32'h10);
    check("store_wdata", 32'(seen_wdata), 32'h5A);
    check("store_keeps_data_B", 32'(data_B), 32'hA5);

    do_access(1'b1, 1'b0, 1'b0, 8'h20, 8'h00, 1, 1'b1, 8'h11);
    check("b2b_first_stall", 32'(last_stall_run), 32'd2);
    check("b2b_first_data", 32'(data_B), 32'h11);
    do_access(1'b1, 1'b0, 1'b0, 8'h21, 8'h00, 1, 1'b1, 8'h22);
    check("b2b_second_stall", 32'(last_stall_run), 32'd2);
    check("b2b_second_req", 32'(last_req_run), 32'd1);
    check("b2b_second_data", 32'(data_B), 32'h22);

    ip_hold  = 1'b1;
    IP       = 8'h3C;
    valid    = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; IO_Write = 1'b1; Rd2 = 8'h77;
    run_cycle(1'b0, 1'b0, 1'b0, 8'h00);
    check("io_out_port", 32'(OUT_port), 32'h77);
    IO_Write = 1'b0; Rd2 = 8'h12;
    run_cycle(1'b0, 1'b0, 1'b0, 8'h00);
    check("io_written_once", 32'(OUT_port), 32'h77);
    check("ip_sync_2_edges", 32'(IP_sync), 32'h3C);
    ip_hold = 1'b0;

    // Asynchronous reset while a load is outstanding.
    valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; IO_Write = 1'b1;
    ALU_res = 8'h44; Rd2 = 8'h09;
    exp_we = 1'b0; exp_addr = 8'h44; exp_wdata = 8'h09;
    run_cycle(1'b1, 1'b0, 1'b0, 8'h00);
    run_cycle(1'b1, 1'b1, 1'b0, 8'h00);
    check("pre_rst_req", 32'(mem_req), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("midrst_mem_req", 32'(mem_req), 32'h0);
    check("midrst_stall", 32'(stall), 32'h0);
    check("midrst_data_B", 32'(data_B), 32'h0);
    check("midrst_OUT_port", 32'(OUT_port), 32'h0);
    check("midrst_mem_addr", 32'(mem_addr), 32'h0);
    valid = 1'b0; MemRead = 1'b0; IO_Write = 1'b0;
    exp_stall = 0; exp_req = 0; exp_err = 0; exp_data_b = 8'h00; exp_out = 8'h00;
    @(posedge clk); #1;
    rst = 1'b1;
    run_cycle(1'b0, 1'b0, 1'b1, 8'hEE);
    run_cycle(1'b0, 1'b0, 1'b0, 8'h00);
    check("late_ack_ignored", 32'(data_B), 32'h0);
    do_access(1'b1, 1'b0, 1'b0, 8'h45, 8'h00, 1, 1'b1, 8'h6B);
    check("post_rst_stall", 32'(last_stall_run), 32'd2);

`ifdef MEM_TIMEOUT_EN
    begin
      int err0;
      err0 = err_pulses;
      do_access(1'b1, 1'b0, 1'b0, 8'h55, 8'h00, 16, 1'b0, 8'h00);
      check("timeout_err_pulse", 32'(err_pulses), 32'(err0 + 1));
      check("timeout_data", 32'(data_B), 32'hFF);
      check("timeout_stall", 32'(last_stall_run), 32'd17);
      do_access(1'b1, 1'b0, 1'b0, 8'h56, 8'h00, 16, 1'b1, 8'h3D);
      check("late_ack_no_err", 32'(err_pulses), 32'(err0 + 1));
      check("late_ack_data", 32'(data_B), 32'h3D);
    end
`endif

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: idle_cycle(1'($urandom), 1'($urandom));
        1: do_access(1'b1, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom),
                     $urandom_range(1, 5), 1'b1, 8'($urandom));
        2: do_access(1'($urandom), 1'b1, 1'($urandom), 8'($urandom), 8'($urandom),
                     $urandom_range(1, 5), 1'b1, 8'($urandom));
        default: idle_cycle(1'b1, 1'b1);
      endcase
    end
    idle_cycle(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage controller between the EX/MEM and MEM/WB pipeline registers.
- Drives a variable-latency 8-bit data memory over a req/ack handshake and stalls the pipeline while an access is outstanding.
- Owns the registered output port and the synchronised input port.
- Produces data_B (load data) and IP_sync, which the MEM/WB register captures.

Parameters:
- ADDR_W, 8, data-memory address width.
- DATA_W, 8, data width.
- TIMEOUT_CYCLES, 16, cycles in BUSY before abort (used only with the optional feature).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- valid  in  1  MEM-stage instruction valid (not a bubble).
- MemRead  in  1  load request.
- MemWrite  in  1  store request.
- IO_Write  in  1  write Rd2 to output port.
- ALU_res  in  ADDR_W  memory address.
- Rd2  in  DATA_W  store / output-port data.
- IP  in  DATA_W  raw asynchronous input port.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  1 = write, registered.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered write data.
- mem_ack  in  1  one-cycle acknowledge from memory.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- data_B  out  DATA_W  last completed load data, registered.
- IP_sync  out  DATA_W  2-flop-synchronised IP.
- OUT_port  out  DATA_W  output-port register.
- stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM; inserts a bubble into MEM/WB.
- mem_err  out  1  one-cycle timeout pulse (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, data_B, IP_sync (both sync stages), OUT_port, mem_err.
  - stall=0.
  - An in-flight request is dropped immediately; a late mem_ack after reset release is ignored.
- access = valid & (MemRead | MemWrite). If MemRead and MemWrite are both 1, the access is a write.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: on access, latch mem_addr=ALU_res, mem_wdata=Rd2, mem_we=MemWrite; mem_req=1 from the next edge; go BUSY. mem_ack in IDLE is ignored.
  - BUSY: hold mem_req and all request fields stable until mem_ack.
    - On mem_ack: mem_req=0 at the next edge; if mem_we=0, data_B<=mem_rdata at that edge; go DONE.
    - mem_ack in the same cycle the request is first asserted is legal, giving minimum latency.
  - DONE: stall=0 for exactly one cycle so the accessing instruction advances into MEM/WB; next state is IDLE. A new access therefore cannot start in DONE.
- stall (combinational) = (IDLE & access) | BUSY; 0 in DONE. Every memory instruction stalls at least 2 cycles (IDLE, BUSY), with ack in the first BUSY cycle.
- data_B holds its value until the next completed load; stores do not change it.
- OUT_port <= Rd2 when valid & IO_Write & ~stall, i.e. once per instruction.
- IP_sync: two flops on IP every cycle, independent of stall.
- Widths are fixed; no arithmetic, no wrap concerns beyond the timeout counter.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES) clears on entering BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYCLES-1 without ack: mem_req=0, data_B<=8'hFF if the access is a read, mem_err=1 for one cycle, go DONE.
  - An ack arriving in that same cycle takes priority: normal completion, no error.
- Not defined: no counter; BUSY waits indefinitely; mem_err is constant 0.

Decomposition:
- Shared package mem_pkg:
  - state enum (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - ADDR_W and DATA_W defaults;
  - constant TIMEOUT_DATA=8'hFF.
- One natural sub-module: sync_2ff (parameterised-width 2-flop synchroniser with async active-low reset) for IP_sync.

Test Plan:
- Reset mid-BUSY: drop rst with mem_req=1 -> mem_req, stall, data_B and OUT_port are 0 immediately; a mem_ack after release is ignored; state is IDLE.
- Load at 0x3C, memory acks 3 cycles after req with 0xA5 -> mem_req high 3 cycles; stall high 4 cycles then low 1 cycle (DONE); data_B=0xA5.
- Store Rd2=0x5A to 0x10 with MemRead=MemWrite=1 -> mem_we=1, mem_wdata=0x5A, mem_addr=0x10; data_B unchanged.
- Back-to-back loads, acks on the first BUSY cycle -> each load stalls exactly 2 cycles; separate req pulses with an IDLE gap; data_B=first then second data.
- IO_Write with Rd2=0x77 while IP steps to 0x3C -> OUT_port=0x77 one edge later, written once; IP_sync=0x3C after 2 edges.
- MEM_TIMEOUT_EN defined, no ack for 16 cycles on a read -> mem_err pulses once, data_B=0xFF, stall drops in DONE; repeat with ack on the final cycle -> no error, real data captured.
